// File: rtl/fir_mac_engine_pkg.sv
// Shared types and helpers for the serial fixed-point FIR / dot-product MAC engine.
package fir_mac_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Width of an index over n entries, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_engine_mac_unit.sv
// Signed WIDTHxWIDTH multiply into a wide accumulator, plus the shift/saturate result stage.
module fir_mac_engine_mac_unit #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ACC_W = 66
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    first,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH-1:0] res,
  output logic                    sat
);

  logic signed [2*WIDTH-1:0] product;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   shifted;
  logic [ACC_W-WIDTH:0]      upper;

  assign product  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  // The first tap starts from zero so a stale sum never leaks into a new result.
  assign acc_base = first ? '0 : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_base + ACC_W'(product);
    end
  end

  assign shifted = acc >>> FRAC;
  assign upper   = shifted[ACC_W-1:WIDTH-1];

  // NOTE: every output gets a default before any branch, so no path leaves a latch behind.
  always_comb begin
    res = shifted[WIDTH-1:0];
    sat = 1'b0;
    if (!((&upper) || (~|upper))) begin
      sat = 1'b1;
      res = shifted[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Serial MAC engine: NTAPS coefficients x NTAPS-deep history, one product per cycle,
// block dot-product (mode 0) or sliding-window FIR (mode 1) behind valid/ready streams.
module fir_mac_engine
  import fir_mac_engine_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int NTAPS = 8,
  localparam int AW    = idx_width(NTAPS),
  localparam int ACC_W = 2*WIDTH + AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             flush,
  input  logic             coeff_wr,
  input  logic [AW-1:0]    coeff_addr,
  input  logic [WIDTH-1:0] coeff_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic             ovf
);

  localparam int FW = $clog2(NTAPS + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(NTAPS);
  localparam logic [AW-1:0] TAP_LAST  = AW'(NTAPS - 1);

  state_e                  state;
  logic [AW-1:0]           tap;
  logic [FW-1:0]           fill;
  logic [FW-1:0]           fill_inc;
  logic                    mode_q;
  logic signed [WIDTH-1:0] coeff [NTAPS];
  logic signed [WIDTH-1:0] hist  [NTAPS];
  logic                    accept;
  logic                    do_flush;
  logic [WIDTH-1:0]        mac_res;
  logic                    mac_sat;

  // A mode change is only legal between results; it restarts the window like a flush.
  assign do_flush = flush || ((state == ST_IDLE) && (mode != mode_q));
  assign accept   = (state == ST_IDLE) && s_valid && s_ready && (mode == mode_q);
  assign fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;

  fir_mac_engine_mac_unit #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (do_flush),
    .en    (state == ST_MAC),
    .first (tap == '0),
    .a     (hist[tap]),
    .b     (coeff[tap]),
    .res   (mac_res),
    .sat   (mac_sat)
  );

  // NOTE: all sequential state uses <= so every flop in this block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tap     <= '0;
      fill    <= '0;
      mode_q  <= 1'b0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      // NOTE: coeff bank and history are flop arrays with defined reset values, so they
      // sit under the async reset like any other register.
      for (int i = 0; i < NTAPS; i++) begin
        coeff[i] <= '0;
        hist[i]  <= '0;
      end
    end else if (do_flush) begin
      state   <= ST_IDLE;
      tap     <= '0;
      fill    <= '0;
      mode_q  <= mode;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (coeff_wr && (int'(coeff_addr) < NTAPS)) coeff[coeff_addr] <= coeff_data;
          if (accept) begin
            hist[0] <= s_data;
            for (int k = NTAPS - 1; k > 0; k--) hist[k] <= hist[k-1];
            if (fill_inc == FILL_FULL) begin
              state   <= ST_MAC;
              tap     <= '0;
              s_ready <= 1'b0;
              busy    <= 1'b1;
              // Block mode consumes the whole window; FIR mode keeps sliding it.
              fill    <= mode_q ? FILL_FULL : '0;
            end else begin
              fill <= fill_inc;
            end
          end
        end
        ST_MAC: begin
          tap <= tap + 1'b1;
          if (tap == TAP_LAST) state <= ST_OUT;
        end
        ST_OUT: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= mac_res;
            if (mac_sat) ovf <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ST_IDLE;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed + randomized bench for fir_mac_engine (WIDTH=32, FRAC=16, NTAPS=4) against a
// plain-arithmetic reference of the windowed dot product.
module tb_fir_mac_engine;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int NTAPS = 4;
  localparam int AW    = 2;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam longint SAT_HI = 64'sd2147483647;
  localparam longint SAT_LO = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             flush = 1'b0;
  logic             coeff_wr = 1'b0;
  logic [AW-1:0]    coeff_addr = '0;
  logic [WIDTH-1:0] coeff_data = '0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_ready = 1'b0;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             busy;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  int mdl_coeff [NTAPS];
  int mdl_hist  [NTAPS];
  int mdl_fill;
  bit mdl_mode;
  bit mdl_ovf;

  always #5 clk = ~clk;

  fir_mac_engine #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .NTAPS (NTAPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .flush      (flush),
    .coeff_wr   (coeff_wr),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .ovf        (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(0, 1048576)) - 524288;
  endfunction

  // y = sum coeff[k] * x[n-k] in exact arithmetic, then >>> FRAC and clamp.
  function automatic logic [31:0] ref_out(output bit sat);
    logic signed [127:0] sum;
    sum = '0;
    for (int k = 0; k < NTAPS; k++) sum += 128'(mdl_coeff[k]) * 128'(mdl_hist[k]);
    sum = sum >>> FRAC;
    sat = 1'b1;
    if (sum > 128'(SAT_HI)) return 32'h7FFF_FFFF;
    if (sum < 128'(SAT_LO)) return 32'h8000_0000;
    sat = 1'b0;
    return sum[31:0];
  endfunction

  task automatic model_flush();
    for (int k = 0; k < NTAPS; k++) mdl_hist[k] = 0;
    mdl_fill = 0;
    mdl_ovf  = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int k = 0; k < NTAPS; k++) mdl_coeff[k] = 0;
    mdl_mode = 1'b0;
  endtask

  task automatic wcoeff(input int addr, input logic [31:0] val);
    coeff_wr   = 1'b1;
    coeff_addr = AW'(addr);
    coeff_data = val;
    tick(1);
    coeff_wr = 1'b0;
    mdl_coeff[addr] = int'(val);
  endtask

  task automatic set_mode(input bit m);
    mode = m;
    tick(1);
    mdl_mode = m;
    model_flush();
  endtask

  task automatic push(input logic [31:0] x, output bit fires);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = x;
    while (!s_ready && n < 50) begin
      tick(1);
      n++;
    end
    check("s_ready_wait", s_ready, 1'b1);
    tick(1);
    s_valid = 1'b0;
    for (int k = NTAPS - 1; k > 0; k--) mdl_hist[k] = mdl_hist[k-1];
    mdl_hist[0] = int'(x);
    if (mdl_fill < NTAPS) mdl_fill++;
    fires = (mdl_fill == NTAPS);
    if (fires && !mdl_mode) mdl_fill = 0;
  endtask

  task automatic push_quiet(input string tag, input logic [31:0] x);
    bit f;
    push(x, f);
    check({tag, "_nofire"}, {f, m_valid, busy}, 3'b000);
  endtask

  task automatic get_result(input string tag, input int hold, input bit poke, output logic [31:0] got);
    logic [31:0] exp;
    bit sat;
    int n;
    n = 0;
    exp = ref_out(sat);
    if (sat) mdl_ovf = 1'b1;
    while (!m_valid && n < 20) begin
      tick(1);
      n++;
    end
    got = m_data;
    check({tag, "_lat"}, n, NTAPS + 1);
    check({tag, "_data"}, m_data, exp);
    check({tag, "_ovf"}, ovf, mdl_ovf);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        coeff_wr   = 1'b1;
        coeff_addr = AW'(i);
        coeff_data = $urandom;
      end
      tick(1);
      check({tag, "_hold"}, {m_valid, s_ready, m_data}, {2'b10, exp});
    end
    coeff_wr = 1'b0;
    m_ready  = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check({tag, "_taken"}, m_valid, 1'b0);
  endtask

  initial begin
    bit f;
    bit stray;
    logic [31:0] got;

    model_reset();

    // Reset values, then s_ready one edge after release.
    #3;
    check("rst_outs", {s_ready, m_valid, busy, ovf, m_data}, 36'h0);
    tick(1);
    rst_n = 1'b1;
    check("rel_pre", s_ready, 1'b0);
    tick(1);
    check("rel_post", s_ready, 1'b1);

    // Async reset in the middle of a MAC run.
    for (int k = 0; k < NTAPS; k++) wcoeff(k, ONE * (k + 1));
    for (int i = 0; i < NTAPS; i++) push(ONE, f);
    tick(2);
    check("pre_abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {m_valid, busy, s_ready}, 3'b000);
    #1;
    rst_n = 1'b1;
    check("abort_rel_pre", s_ready, 1'b0);
    tick(1);
    check("abort_rel_post", s_ready, 1'b1);
    model_reset();
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      stray |= m_valid;
    end
    check("abort_no_stray", stray, 1'b0);

    // Block dot-product: coeffs 1..4, four samples of 1.0 -> 10.0; fill restarts.
    for (int k = 0; k < NTAPS; k++) wcoeff(k, ONE * (k + 1));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NTAPS - 1; i++) push_quiet("blk", ONE);
      push(ONE, f);
      check("blk_fires", f, 1'b1);
      get_result("blk", 0, 1'b0, got);
      check("blk_ten", got, 32'h000A_0000);
    end

    // Backpressure: result held, s_ready low, coeff writes dropped.
    for (int i = 0; i < NTAPS; i++) push(rnd_val(), f);
    get_result("bp", 10, 1'b1, got);
    for (int i = 0; i < NTAPS; i++) push(rnd_val(), f);
    get_result("bp_after", 0, 1'b0, got);

    // Sliding FIR: samples 1..5 -> 20.0 then 30.0.
    for (int k = 0; k < NTAPS; k++) wcoeff(k, ONE * (k + 1));
    set_mode(1'b1);
    check("mode1_idle", {busy, m_valid, s_ready}, 3'b001);
    for (int i = 1; i < NTAPS; i++) push_quiet("fir", ONE * i);
    push(ONE * 4, f);
    get_result("fir4", 0, 1'b0, got);
    check("fir_twenty", got, 32'h0014_0000);
    push(ONE * 5, f);
    get_result("fir5", 0, 1'b0, got);
    check("fir_thirty", got, 32'h001E_0000);

    // Randomized sliding FIR with occasional coefficient updates and downstream stalls.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0) wcoeff($urandom_range(0, NTAPS - 1), rnd_val());
      push(rnd_val(), f);
      check("rnd_fires", f, 1'b1);
      get_result("rnd", $urandom_range(0, 3), 1'b0, got);
    end

    // Saturation both ways, ovf sticky.
    set_mode(1'b0);
    for (int k = 0; k < NTAPS; k++) wcoeff(k, 32'h7FFF_0000);
    for (int i = 0; i < NTAPS; i++) push(32'h7FFF_0000, f);
    get_result("sat_pos", 0, 1'b0, got);
    check("sat_pos_val", {got, ovf}, {32'h7FFF_FFFF, 1'b1});
    for (int i = 0; i < NTAPS; i++) push(32'h8001_0000, f);
    get_result("sat_neg", 0, 1'b0, got);
    check("sat_neg_val", {got, ovf}, {32'h8000_0000, 1'b1});

    // Flush mid-MAC: nothing emitted, ovf cleared, next window uses new samples only.
    for (int k = 0; k < NTAPS; k++) wcoeff(k, rnd_val());
    for (int i = 0; i < NTAPS; i++) push(rnd_val(), f);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    model_flush();
    check("flush_outs", {m_valid, busy, ovf, s_ready}, 4'b0001);
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      stray |= m_valid;
    end
    check("flush_no_stray", stray, 1'b0);
    for (int i = 0; i < NTAPS - 1; i++) push_quiet("post_flush", rnd_val());
    push(rnd_val(), f);
    get_result("post_flush", 0, 1'b0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
